mc_sequencer: RTL and testbench

//   Multicycle control FSM for the non-pipelined CPU. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/cpu_ctrl_pkg.sv | 29 ++
 rtl/mc_wait_timer.sv | 32 +++
 rtl/mc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_mc_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control constants for the multicycle CPU: FSM state encodings and op classes.
// The instruction decoder imports the same op-class values.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] OPC_ALU    = 3'd0;
  localparam logic [2:0] OPC_LOAD   = 3'd1;
  localparam logic [2:0] OPC_STORE  = 3'd2;
  localparam logic [2:0] OPC_BRANCH = 3'd3;
  localparam logic [2:0] OPC_JUMP   = 3'd4;
  localparam logic [2:0] OPC_MULDIV = 3'd5;
  localparam logic [2:0] OPC_HALT   = 3'd6;
  localparam logic [2:0] OPC_ILL    = 3'd7;

  // States in which the FSM holds a request on the shared memory port.
  function automatic logic is_mem_wait(state_e s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts un-acked request cycles and flags the last allowed one.
module mc_wait_timer #(
  parameter int unsigned WAIT_W     = 8,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [WAIT_W-1:0] LastCnt = WAIT_W'(WAIT_LIMIT - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  // High on the WAIT_LIMIT-th request cycle; an ack in that cycle still wins.
  assign expired_o = (cnt_q == LastCnt);

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives state-register enables, and handshakes with memory and the mul/div unit.
module mc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255,
  parameter int unsigned WAIT_W     = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op_class,
  input  logic             br_taken,
  input  logic             md_wb,
  input  logic             md_done,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             pc_wena,
  output logic             pc_rena,
  output logic             ir_wena,
  output logic             mdr_wena,
  output logic             rf_wena,
  output logic             md_start,
  output logic             halted,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  state_e             state_q, state_d;
  logic [2:0]         opc_q, opc_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic               retire;
  logic               waiting;
  logic               expired;
  logic               timeout;

  assign waiting = is_mem_wait(state_q);
  assign timeout = waiting && expired && !mem_ack;

  mc_wait_timer #(
    .WAIT_W     (WAIT_W),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk_i     (clk),
    .clr_i     (rst || !waiting || mem_ack),
    .inc_i     (waiting && !mem_ack),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_DECODE: begin
        opc_d = op_class;
        unique case (op_class)
          OPC_JUMP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OPC_HALT: state_d = S_HALT;
          OPC_ILL: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (opc_q)
          OPC_ALU:             state_d = S_WB;
          OPC_LOAD, OPC_STORE: state_d = S_MEM;
          OPC_BRANCH: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OPC_MULDIV:          state_d = S_MDWAIT;
          default:             state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          if (opc_q == OPC_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d   = S_HALT;
          bus_err_d = 1'b1;
        end
      end
      S_MDWAIT: begin
        if (md_done) begin
          if (md_wb) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      opc_q     <= OPC_ALU;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Enables are decoded from the state register and forced low while rst is asserted.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    pc_wena  = 1'b0;
    pc_rena  = 1'b0;
    ir_wena  = 1'b0;
    mdr_wena = 1'b0;
    rf_wena  = 1'b0;
    md_start = 1'b0;
    if (!rst) begin
      pc_rena = (state_q != S_HALT);
      unique case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          pc_wena = mem_ack;
          ir_wena = mem_ack;
        end
        S_DECODE: pc_wena = (op_class == OPC_JUMP);
        S_EXEC: begin
          pc_wena  = (opc_q == OPC_BRANCH) && br_taken;
          md_start = (opc_q == OPC_MULDIV);
        end
        S_MEM: begin
          mem_req  = 1'b1;
          mem_we   = (opc_q == OPC_STORE);
          mdr_wena = mem_ack && (opc_q == OPC_LOAD);
        end
        S_WB:    rf_wena = 1'b1;
        default: ;
      endcase
    end
  end

  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: instruction-level model expands each instruction into a table of
// per-cycle {inputs, expected outputs} records, which a single loop applies and compares.
module tb_mc_sequencer;

  localparam int WL = 4;
  localparam int CW = 4;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC = 2, ST_MEM = 3;
  localparam int ST_WB = 4, ST_MDWAIT = 5, ST_HALT = 6;
  localparam int OP_ALU = 0, OP_LD = 1, OP_ST = 2, OP_BR = 3, OP_J = 4, OP_MD = 5;
  localparam int OP_HLT = 6, OP_ILL = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    op_class = '0;
  logic          br_taken = 1'b0, md_wb = 1'b0, md_done = 1'b0, mem_ack = 1'b0;
  logic          mem_req, mem_we, pc_wena, pc_rena, ir_wena, mdr_wena, rf_wena, md_start;
  logic          halted, illegal, bus_err;
  logic [CW-1:0] instret;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  mc_sequencer #(
    .WAIT_LIMIT (WL),
    .WAIT_W     (3),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_class (op_class),
    .br_taken (br_taken),
    .md_wb    (md_wb),
    .md_done  (md_done),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .pc_wena  (pc_wena),
    .pc_rena  (pc_rena),
    .ir_wena  (ir_wena),
    .mdr_wena (mdr_wena),
    .rf_wena  (rf_wena),
    .md_start (md_start),
    .halted   (halted),
    .illegal  (illegal),
    .bus_err  (bus_err),
    .instret  (instret),
    .state_o  (state_o)
  );

  typedef struct {
    string      tag;
    logic       rst, ack, mdd, br, mdwb;
    logic [2:0] op;
    logic       en_only;
    logic [2:0] st;
    logic       req, we, pcw, pcr, irw, mdrw, rfw, mds, hlt, ill, berr;
    int         ret;
  } cyc_t;

  cyc_t plan[$];
  int   m_ret;
  logic m_ill, m_berr, m_hlt;
  int   n_chk, n_pass;

  // Unconstrained inputs are random so that ignored inputs really are ignored.
  function automatic cyc_t blank(string tag, int st);
    cyc_t r;
    r.tag = tag;   r.rst = 1'b0;
    r.ack = 1'($urandom_range(0, 1));  r.mdd = 1'($urandom_range(0, 1));
    r.br  = 1'($urandom_range(0, 1));  r.mdwb = 1'($urandom_range(0, 1));
    r.op  = 3'($urandom_range(0, 7));
    r.en_only = 1'b0;  r.st = 3'(st);
    r.req = 0; r.we = 0; r.pcw = 0; r.pcr = 1; r.irw = 0; r.mdrw = 0; r.rfw = 0; r.mds = 0;
    r.hlt = 0; r.ill = m_ill; r.berr = m_berr; r.ret = m_ret;
    return r;
  endfunction

  task automatic do_reset(string tag, logic ack);
    cyc_t r = blank(tag, ST_FETCH);
    r.rst = 1'b1; r.ack = ack; r.en_only = 1'b1; r.pcr = 1'b0;
    plan.push_back(r);
    m_ret = 0; m_ill = 1'b0; m_berr = 1'b0; m_hlt = 1'b0;
  endtask

  task automatic do_halt(string tag, int n);
    cyc_t r;
    m_hlt = 1'b1;
    for (int i = 0; i < n; i++) begin
      r = blank(tag, ST_HALT); r.hlt = 1'b1; r.pcr = 1'b0;
      plan.push_back(r);
    end
  endtask

  task automatic mem_wait(string tag, int st, int n, logic we);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      r = blank(tag, st); r.ack = 1'b0; r.req = 1'b1; r.we = we;
      plan.push_back(r);
    end
  endtask

  // One instruction; fd/mdly >= WL means the memory never answers.
  task automatic instr(string tag, int op, logic br, logic wb, int fd, int mdly, int mddly);
    cyc_t r;
    mem_wait(tag, ST_FETCH, (fd < WL) ? fd : WL, 1'b0);
    if (fd >= WL) begin m_berr = 1'b1; do_halt(tag, 3); return; end
    r = blank(tag, ST_FETCH); r.ack = 1; r.req = 1; r.pcw = 1; r.irw = 1; plan.push_back(r);
    r = blank(tag, ST_DECODE); r.op = 3'(op); r.pcw = (op == OP_J); plan.push_back(r);
    if (op == OP_J) begin m_ret++; return; end
    if (op >= OP_HLT) begin
      if (op == OP_ILL) m_ill = 1'b1;
      do_halt(tag, 3);
      return;
    end
    r = blank(tag, ST_EXEC); r.br = br; r.pcw = (op == OP_BR) && br; r.mds = (op == OP_MD);
    plan.push_back(r);
    case (op)
      OP_BR: begin m_ret++; return; end
      OP_LD, OP_ST: begin
        mem_wait(tag, ST_MEM, (mdly < WL) ? mdly : WL, op == OP_ST);
        if (mdly >= WL) begin m_berr = 1'b1; do_halt(tag, 3); return; end
        r = blank(tag, ST_MEM); r.ack = 1; r.req = 1; r.we = (op == OP_ST); r.mdrw = (op == OP_LD);
        plan.push_back(r);
        if (op == OP_ST) begin m_ret++; return; end
      end
      OP_MD: begin
        for (int i = 0; i < mddly; i++) begin
          r = blank(tag, ST_MDWAIT); r.mdd = 1'b0; plan.push_back(r);
        end
        r = blank(tag, ST_MDWAIT); r.mdd = 1'b1; r.mdwb = wb; plan.push_back(r);
        if (!wb) begin m_ret++; return; end
      end
      default: ;
    endcase
    r = blank(tag, ST_WB); r.rfw = 1'b1; plan.push_back(r);
    m_ret++;
  endtask

  initial begin
    cyc_t        r;
    logic [17:0] act, exp;
    logic [3:0]  to_act, to_exp;
    int          op, fd, md;
    m_ret = 0; m_ill = 0; m_berr = 0; m_hlt = 0; n_chk = 0; n_pass = 0;

    // Directed corner cases.
    do_reset("rst0", 1'b1);
    instr("alu", OP_ALU, 0, 0, 0, 0, 0);
    instr("load_d3", OP_LD, 0, 0, 0, 3, 0);
    instr("br_t", OP_BR, 1, 0, 0, 0, 0);
    instr("br_nt", OP_BR, 0, 0, 0, 0, 0);
    instr("md_33", OP_MD, 0, 0, 0, 0, 32);
    instr("md_wb", OP_MD, 0, 1, 1, 0, 0);
    instr("jump", OP_J, 0, 0, WL - 1, 0, 0);
    instr("st_lim", OP_ST, 0, 0, 0, WL - 1, 0);
    instr("fetch_to", OP_ALU, 0, 0, WL, 0, 0);
    do_reset("rst_to", 1'b0);
    instr("post_to", OP_ALU, 0, 0, 0, 0, 0);
    instr("ill", OP_ILL, 0, 0, 0, 0, 0);
    do_reset("rst_ill", 1'b0);
    instr("hlt", OP_HLT, 0, 0, 2, 0, 0);
    do_reset("rst_hlt", 1'b0);
    instr("mem_to", OP_LD, 0, 0, 0, WL, 0);
    do_reset("rst_mto", 1'b0);
    // Reset in MEM mid-request with a pending ack.
    instr("pre", OP_ALU, 0, 0, 0, 0, 0);
    r = blank("mid_f", ST_FETCH); r.ack = 1; r.req = 1; r.pcw = 1; r.irw = 1; plan.push_back(r);
    r = blank("mid_d", ST_DECODE); r.op = 3'(OP_ST); plan.push_back(r);
    r = blank("mid_e", ST_EXEC); plan.push_back(r);
    mem_wait("mid_m", ST_MEM, 2, 1'b1);
    do_reset("rst_mem", 1'b1);
    mem_wait("after_rst", ST_FETCH, 1, 1'b0);
    for (int i = 0; i < 18; i++) instr("wrap", OP_ALU, 0, 0, 0, 0, 0);

    // Randomized instruction stream.
    do_reset("rand_rst0", 1'b0);
    for (int k = 0; k < 250; k++) begin
      op = $urandom_range(0, 15);
      op = (op < 14) ? op % 6 : op - 8;
      fd = ($urandom_range(0, 11) == 0) ? WL : $urandom_range(0, WL - 1);
      md = ($urandom_range(0, 11) == 0) ? WL : $urandom_range(0, WL - 1);
      instr("rand", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fd, md,
            $urandom_range(0, 40));
      if (m_hlt) do_reset("rand_rst", 1'($urandom_range(0, 1)));
    end
    mem_wait("final", ST_FETCH, 1, 1'b0);

    for (int i = 0; i < plan.size(); i++) begin
      @(posedge clk);
      #1;
      rst = plan[i].rst; op_class = plan[i].op; br_taken = plan[i].br;
      md_wb = plan[i].mdwb; md_done = plan[i].mdd; mem_ack = plan[i].ack;
      @(negedge clk);
      n_chk++;
      if (plan[i].en_only) begin
        act = {10'd0, mem_req, mem_we, pc_wena, pc_rena, ir_wena, mdr_wena, rf_wena, md_start};
        exp = '0;
        if (act === exp) n_pass++;
        else $display("FAIL reset %s cyc=%0d got=%h exp=%h", plan[i].tag, i, act, exp);
      end else begin
        act = {state_o, mem_req, mem_we, pc_wena, pc_rena, ir_wena, mdr_wena, rf_wena, md_start,
               halted, illegal, bus_err, instret};
        exp = {plan[i].st, plan[i].req, plan[i].we, plan[i].pcw, plan[i].pcr, plan[i].irw,
               plan[i].mdrw, plan[i].rfw, plan[i].mds, plan[i].hlt, plan[i].ill, plan[i].berr,
               CW'(plan[i].ret)};
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", plan[i].tag, i, act, exp);
        if (plan[i].berr && plan[i].hlt) begin
          n_chk++;
          to_act = {halted, bus_err, pc_rena, mem_req};
          to_exp = 4'b1100;
          if (to_act === to_exp) n_pass++;
          else $display("FAIL timeout %s cyc=%0d got=%b exp=%b", plan[i].tag, i, to_act, to_exp);
        end
      end
    end

    if (n_pass != n_chk) $error("FAIL %0d of %0d checks failed", n_chk - n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
